// File: rtl/cgol_ws_pkg.sv
// rtl/cgol_ws_pkg.sv - shared types and constants for the WS2812B output path
package cgol_ws_pkg;

    localparam int GRB_W          = 24;
    localparam int BITS_PER_PIXEL = 24;

    localparam logic [GRB_W-1:0] DEFAULT_ALIVE_GRB = 24'h10_00_00;
    localparam logic [GRB_W-1:0] DEFAULT_DEAD_GRB  = 24'h00_00_00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_SEND,
        ST_LATCH
    } stream_state_t;

endpackage

// File: rtl/ws_latch_timer.sv
// rtl/ws_latch_timer.sv - down-counter that pulses o_done in the CYCLES-th cycle after i_start
module ws_latch_timer #(
    parameter int CYCLES = 3600
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_start,
    output logic o_done
);

    localparam int CNT_W = $clog2(CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;

    // cnt holds the cycles still to run after the current one; done is registered one early
    always_comb begin
        cnt_d  = cnt_q;
        done_d = 1'b0;
        if (i_start) begin
            cnt_d  = CNT_W'(CYCLES - 1);
            done_d = (CYCLES == 1);
        end else if (cnt_q != '0) begin
            cnt_d  = cnt_q - CNT_W'(1);
            done_d = (cnt_q == CNT_W'(1));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign o_done = done_q;

endmodule

// File: rtl/cgol_frame_streamer.sv
// rtl/cgol_frame_streamer.sv - walks the cell memory and serialises GRB colours to the WS2812B driver
module cgol_frame_streamer
    import cgol_ws_pkg::*;
#(
    parameter int               NUM_PIXELS   = 64,
    parameter int               ADDR_W       = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1,
    parameter logic [GRB_W-1:0] ALIVE_GRB    = DEFAULT_ALIVE_GRB,
    parameter logic [GRB_W-1:0] DEAD_GRB     = DEFAULT_DEAD_GRB,
    parameter int               LATCH_CYCLES = 3600
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    output logic              o_busy,
    output logic              o_done,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic              mem_rd_data,
    output logic              o_serial,
    output logic              o_transmit,
    input  logic              i_shift
);

    stream_state_t     state_q, state_d;
    logic [ADDR_W-1:0] pix_idx_q, pix_idx_d;
    logic [4:0]        bit_cnt_q, bit_cnt_d;
    logic [GRB_W-1:0]  shift_reg_q, shift_reg_d;
    logic [GRB_W-1:0]  next_grb_q, next_grb_d;
    logic              next_valid_q, next_valid_d;
    logic              pf_due_q, pf_due_d;
    logic              mem_rd_en_q, mem_rd_en_d;
    logic [ADDR_W-1:0] mem_rd_addr_q, mem_rd_addr_d;
    logic              transmit_q, transmit_d;
    logic              busy_q, busy_d;
    logic              latch_start, latch_done;

    logic [ADDR_W:0]   pf_idx;
    logic              pf_exists, last_pix, pix_adv;

    function automatic logic [GRB_W-1:0] map_grb(input logic alive);
        return alive ? ALIVE_GRB : DEAD_GRB;
    endfunction

    assign pf_idx    = {1'b0, pix_idx_q} + (ADDR_W+1)'(2);
    assign pf_exists = pf_idx < (ADDR_W+1)'(NUM_PIXELS);
    assign last_pix  = pix_idx_q == ADDR_W'(NUM_PIXELS - 1);
    assign pix_adv   = (state_q == ST_SEND) && i_shift && (bit_cnt_q == 5'd23) && !last_pix;

    always_comb begin
        state_d       = state_q;
        pix_idx_d     = pix_idx_q;
        bit_cnt_d     = bit_cnt_q;
        shift_reg_d   = shift_reg_q;
        next_grb_d    = next_grb_q;
        next_valid_d  = next_valid_q;
        mem_rd_en_d   = 1'b0;
        mem_rd_addr_d = mem_rd_addr_q;
        transmit_d    = transmit_q;
        busy_d        = busy_q;
        latch_start   = 1'b0;
        // prefetch strobes only ever occur in SEND; their data lands one cycle later
        pf_due_d      = mem_rd_en_q && (state_q == ST_SEND);

        if (pf_due_q) begin
            next_grb_d   = map_grb(mem_rd_data);
            next_valid_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d       = ST_FETCH;
                    pix_idx_d     = '0;
                    busy_d        = 1'b1;
                    mem_rd_en_d   = 1'b1;
                    mem_rd_addr_d = '0;
                end
            end
            ST_FETCH: state_d = ST_LOAD;
            ST_LOAD: begin
                shift_reg_d = map_grb(mem_rd_data);
                bit_cnt_d   = '0;
                transmit_d  = 1'b1;
                if (NUM_PIXELS > 1) begin
                    mem_rd_en_d   = 1'b1;
                    mem_rd_addr_d = ADDR_W'(1);
                end
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (i_shift) begin
                    shift_reg_d = shift_reg_q << 1;
                    bit_cnt_d   = bit_cnt_q + 5'd1;
                    if (bit_cnt_q == 5'd23) begin
                        bit_cnt_d = '0;
                        if (!last_pix) begin
                            shift_reg_d  = next_grb_q;
                            next_valid_d = 1'b0;
                            pix_idx_d    = pix_idx_q + ADDR_W'(1);
                            if (pf_exists) begin
                                mem_rd_en_d   = 1'b1;
                                mem_rd_addr_d = pf_idx[ADDR_W-1:0];
                            end
                        end else begin
                            transmit_d  = 1'b0;
                            latch_start = 1'b1;
                            state_d     = ST_LATCH;
                        end
                    end
                end
            end
            ST_LATCH: begin
                if (latch_done) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            pix_idx_q     <= '0;
            bit_cnt_q     <= '0;
            shift_reg_q   <= '0;
            next_grb_q    <= '0;
            next_valid_q  <= 1'b0;
            pf_due_q      <= 1'b0;
            mem_rd_en_q   <= 1'b0;
            mem_rd_addr_q <= '0;
            transmit_q    <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            pix_idx_q     <= pix_idx_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_reg_q   <= shift_reg_d;
            next_grb_q    <= next_grb_d;
            next_valid_q  <= next_valid_d;
            pf_due_q      <= pf_due_d;
            mem_rd_en_q   <= mem_rd_en_d;
            mem_rd_addr_q <= mem_rd_addr_d;
            transmit_q    <= transmit_d;
            busy_q        <= busy_d;
        end
    end

    ws_latch_timer #(
        .CYCLES (LATCH_CYCLES)
    ) u_latch_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (latch_start),
        .o_done  (latch_done)
    );

    // a boundary without a captured prefetch means the driver shifted faster than allowed
    next_valid_at_boundary: assert property (@(posedge clk) disable iff (!rst_n) pix_adv |-> next_valid_q);

    assign o_busy      = busy_q;
    assign o_done      = latch_done;
    assign mem_rd_en   = mem_rd_en_q;
    assign mem_rd_addr = mem_rd_addr_q;
    assign o_serial    = shift_reg_q[GRB_W-1];
    assign o_transmit  = transmit_q;

endmodule
